// File: rtl/key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : key_event_decoder
// Description : Classifies a debounced button level into short-press,
//               long-press and auto-repeat events. Each event is a one-cycle
//               registered pulse for the LED effect controller. A prescaler
//               divides the clock into timing ticks. A tick counter measures
//               how long the button has been held.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1  system clock
//   reset_n      in   1  asynchronous active-low reset
//   pressed      in   1  debounced button level, 1 = pressed
//   enable       in   1  1 = decode events, 0 = force IDLE, no events
//   ev_short     out  1  pulse: released before the long threshold
//   ev_long      out  1  pulse: long threshold reached while held
//   ev_repeat    out  1  pulse: every REPEAT_TICKS while held after ev_long
//   held         out  1  level: button is being tracked (HELD or LONG)
//   press_count  out  8  count of ev_short + ev_long, wraps 255 -> 0
// ============================================================================
module key_event_decoder #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned LONG_TICKS   = 800,
  parameter int unsigned REPEAT_TICKS = 200,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pressed,
  input  logic       enable,
  output logic       ev_short,
  output logic       ev_long,
  output logic       ev_repeat,
  output logic       held,
  output logic [7:0] press_count
);

  // Terminal values. The tick counter is compared against "threshold - 1",
  // because the transition fires on the tick that brings it to the threshold.
  localparam logic [CNT_W-1:0] C_PRESC_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic             r_pressed_q;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_ev_short;
  logic             r_ev_long;
  logic             r_ev_repeat;
  logic             r_held;
  logic [7:0]       r_press_count;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_rise;
  logic             w_fall;
  logic             w_tick;
  logic             w_entering;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_presc_nxt;
  logic [CNT_W-1:0] w_tick_cnt_nxt;
  logic             w_ev_short_nxt;
  logic             w_ev_long_nxt;
  logic             w_ev_repeat_nxt;
  logic             w_press_inc;

  assign w_rise = pressed & ~r_pressed_q;
  assign w_fall = ~pressed & r_pressed_q;

  // The prescaler only runs in HELD/LONG, so a tick can never be seen in IDLE.
  assign w_tick = (r_state != S_IDLE) && (r_presc == C_PRESC_MAX);

  // --------------------------------------------------------------------------
  // Next-state and event decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_ev_short_nxt  = 1'b0;
    w_ev_long_nxt   = 1'b0;
    w_ev_repeat_nxt = 1'b0;
    w_press_inc     = 1'b0;

    if (!enable) begin
      // Disabling abandons any press in progress without an event.
      w_state_nxt    = S_IDLE;
      w_tick_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_state_nxt    = S_HELD;
            w_tick_cnt_nxt = '0;
          end
        end

        S_HELD: begin
          // A release beats a long threshold on the same edge.
          if (w_fall) begin
            w_ev_short_nxt = 1'b1;
            w_press_inc    = 1'b1;
            w_state_nxt    = S_IDLE;
          end else if (w_tick) begin
            if (r_tick_cnt == C_LONG_LAST) begin
              w_ev_long_nxt  = 1'b1;
              w_press_inc    = 1'b1;
              w_state_nxt    = S_LONG;
              w_tick_cnt_nxt = '0;
            end else begin
              w_tick_cnt_nxt = r_tick_cnt + 1'b1;
            end
          end
        end

        S_LONG: begin
          // A release suppresses a repeat tick on the same edge.
          if (w_fall) begin
            w_state_nxt = S_IDLE;
          end else if (w_tick) begin
            if (r_tick_cnt == C_REPEAT_LAST) begin
              w_ev_repeat_nxt = 1'b1;
              w_tick_cnt_nxt  = '0;
            end else begin
              w_tick_cnt_nxt = r_tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt    = S_IDLE;
          w_tick_cnt_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Prescaler next value: restarts on every entry into HELD or LONG so that
  // the first tick lands exactly TICK_DIV edges after the entry edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_entering  = (w_state_nxt != r_state) && (w_state_nxt != S_IDLE);
    w_presc_nxt = '0;
    if ((w_state_nxt != S_IDLE) && !w_entering) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      // Starts high so that a button held through reset is not a rise.
      r_pressed_q   <= 1'b1;
      r_presc       <= '0;
      r_tick_cnt    <= '0;
      r_ev_short    <= 1'b0;
      r_ev_long     <= 1'b0;
      r_ev_repeat   <= 1'b0;
      r_held        <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pressed_q   <= pressed;
      r_presc       <= w_presc_nxt;
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_ev_short    <= w_ev_short_nxt;
      r_ev_long     <= w_ev_long_nxt;
      r_ev_repeat   <= w_ev_repeat_nxt;
      r_held        <= (w_state_nxt != S_IDLE);
      if (w_press_inc) begin
        r_press_count <= r_press_count + 8'd1;
      end
    end
  end

  assign ev_short    = r_ev_short;
  assign ev_long     = r_ev_long;
  assign ev_repeat   = r_ev_repeat;
  assign held        = r_held;
  assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_decoder
// Description : Self-checking bench for key_event_decoder (TICK_DIV=4,
//               LONG_TICKS=5, REPEAT_TICKS=3). Expected events are pushed to a
//               queue as presses are driven. Observed pulses are collected by a
//               monitor. Each scenario task compares the two queues itself.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_decoder;

  localparam int TD = 4;
  localparam int LT = 5;
  localparam int RT = 3;

  typedef struct packed {
    logic [1:0]  kind;     // 0 short, 1 long, 2 repeat
    logic [31:0] edge_no;  // clock edge on which the condition was evaluated
  } ev_t;

  logic       clock;
  logic       reset_n;
  logic       pressed;
  logic       enable;
  logic       ev_short;
  logic       ev_long;
  logic       ev_repeat;
  logic       held;
  logic [7:0] press_count;

  int         cyc;
  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_pc;
  ev_t        exp_q[$];
  ev_t        obs_q[$];

  key_event_decoder #(
    .TICK_DIV     (TD),
    .LONG_TICKS   (LT),
    .REPEAT_TICKS (RT),
    .CNT_W        (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pressed     (pressed),
    .enable      (enable),
    .ev_short    (ev_short),
    .ev_long     (ev_long),
    .ev_repeat   (ev_repeat),
    .held        (held),
    .press_count (press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int k, input int e);
    ev_t v;
    v.kind    = 2'(k);
    v.edge_no = 32'(e);
    return v;
  endfunction

  // A pulse seen at a negedge belongs to the posedge just before it (index cyc).
  always @(negedge clock) begin
    if (ev_short)  obs_q.push_back(mk_ev(0, cyc));
    if (ev_long)   obs_q.push_back(mk_ev(1, cyc));
    if (ev_repeat) obs_q.push_back(mk_ev(2, cyc));
  end

  // Reference model of one enabled press from IDLE: rise on edge r, fall on r+n.
  task automatic model_press(input int r, input int n);
    if (n <= LT * TD) begin
      exp_q.push_back(mk_ev(0, r + n));
      exp_pc = exp_pc + 8'd1;
    end else begin
      exp_q.push_back(mk_ev(1, r + LT * TD));
      exp_pc = exp_pc + 8'd1;
      for (int e = r + LT * TD + RT * TD; e < r + n; e += RT * TD)
        exp_q.push_back(mk_ev(2, e));
    end
  endtask

  // Hold pressed for n cycles; the fall is sampled n edges after the rise.
  task automatic do_press(input int n, input bit expect_ev);
    int r;
    @(negedge clock);
    pressed = 1'b1;
    r = cyc + 1;
    if (expect_ev) model_press(r, n);
    repeat (n) @(negedge clock);
    pressed = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    pressed = 1'b1;
    enable  = 1'b1;
    exp_pc  = 8'd0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({ev_short, ev_long, ev_repeat, held} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, expected 0000", {ev_short, ev_long, ev_repeat, held});
    end
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL reset_count: got %0d, expected %0d", press_count, exp_pc);
    end
    // Button stays pressed through and after reset release: no rise.
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_held_idle: got %b, expected 0", held);
    end
    pressed = 1'b0;
    settle();
    do_press(8, 1'b1);
    settle();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL reset_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL reset_after_count: got %0d, expected %0d", press_count, exp_pc);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_short();
    int r;
    @(negedge clock);
    pressed = 1'b1;
    r = cyc + 1;
    model_press(r, 10);
    repeat (4) @(negedge clock);
    n_cmp++;
    if (held !== 1'b1) begin
      n_bad++;
      $display("FAIL short_held_mid: got %b, expected 1", held);
    end
    repeat (6) @(negedge clock);
    pressed = 1'b0;
    settle();
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL short_held_after: got %b, expected 0", held);
    end
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL short_count: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL short_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL short_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // 60-cycle hold: long at +20, repeats at +32, +44 and +56, no short.
  task automatic test_long();
    do_press(60, 1'b1);
    settle();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL long_count: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL long_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL long_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_boundary();
    do_press(20, 1'b1);
    settle();
    do_press(19, 1'b1);
    settle();
    do_press(21, 1'b1);
    settle();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL boundary_count: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL boundary_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL boundary_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_enable();
    // Whole press while disabled.
    enable = 1'b0;
    do_press(30, 1'b0);
    settle();
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_off_held: got %b, expected 0", held);
    end
    // Enable raised mid-press: no rise seen, so nothing until a fresh press.
    @(negedge clock);
    pressed = 1'b1;
    repeat (5) @(negedge clock);
    enable = 1'b1;
    repeat (30) @(negedge clock);
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_raise_held: got %b, expected 0", held);
    end
    pressed = 1'b0;
    settle();
    // Enable dropped while in HELD: press abandoned, long threshold suppressed.
    @(negedge clock);
    pressed = 1'b1;
    repeat (8) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_drop_held: got %b, expected 0", held);
    end
    repeat (20) @(negedge clock);
    pressed = 1'b0;
    settle();
    enable = 1'b1;
    settle();
    do_press(6, 1'b1);
    settle();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL enable_count: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL enable_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL enable_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap();
    @(negedge clock);
    reset_n = 1'b0;
    exp_pc  = 8'd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    settle();
    for (int i = 0; i < 256; i++) begin
      do_press(2, 1'b1);
      repeat (2) @(negedge clock);
      if (i == 254) begin
        n_cmp++;
        if (press_count !== exp_pc) begin
          n_bad++;
          $display("FAIL wrap_255: got %0d, expected %0d", press_count, exp_pc);
        end
      end
    end
    settle();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL wrap_zero: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL wrap_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL wrap_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_long();
    int r;
    @(negedge clock);
    pressed = 1'b1;
    r = cyc + 1;
    exp_q.push_back(mk_ev(1, r + LT * TD));
    exp_pc = exp_pc + 8'd1;
    repeat (25) @(negedge clock);
    n_cmp++;
    if (held !== 1'b1 || press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL midlong_before: got held %b count %0d, expected held 1 count %0d", held, press_count, exp_pc);
    end
    // Assert reset between clock edges: outputs must clear without an edge.
    #2;
    reset_n = 1'b0;
    exp_pc  = 8'd0;
    #1;
    n_cmp++;
    if ({ev_short, ev_long, ev_repeat, held} !== 4'b0000 || press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL midlong_async: got flags %b count %0d, expected 0000 count %0d", {ev_short, ev_long, ev_repeat, held}, press_count, exp_pc);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (15) @(negedge clock);
    n_cmp++;
    if (held !== 1'b0) begin
      n_bad++;
      $display("FAIL midlong_held_after: got %b, expected 0", held);
    end
    pressed = 1'b0;
    settle();
    do_press(4, 1'b1);
    settle();
    n_cmp++;
    if (press_count !== exp_pc) begin
      n_bad++;
      $display("FAIL midlong_count: got %0d, expected %0d", press_count, exp_pc);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL midlong_evcount: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ev_t o, e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL midlong_event: got kind %0d edge %0d, expected kind %0d edge %0d", o.kind, o.edge_no, e.kind, e.edge_no);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    cyc     = 0;
    n_cmp   = 0;
    n_bad   = 0;
    exp_pc  = 8'd0;
    reset_n = 1'b0;
    pressed = 1'b1;
    enable  = 1'b1;

    test_reset();
    test_short();
    test_long();
    test_boundary();
    test_enable();
    test_wrap();
    test_reset_mid_long();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
